tlb_ctrl: RTL and testbench
===========================

# tlb_ctrl

Sequencer and arbiter in front of the set-associative TLB. It shares one TLB lookup port between `NREQ` translation requesters using round-robin grant. On a miss it runs a page-table-walk handshake, inserts the walked PTE, and returns the translated address to the requester. It also owns TLB flush sequencing, so nothing else drives the TLB's lookup, insert or shutdown controls.

## Interface
Parameters:
- `SADDR`, 64, address width
- `SPAGE`, 12, page-offset width
- `SPCID`, 12, PCID width
- `NREQ`, 2, number of requesters
- `FLUSH_CYCLES`, 2, cycles `tlb_shutdown` is held high
- `TIMEOUT`, 8, maximum WAIT cycles before a lookup is treated as a miss

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  one-hot accept
- `req_va`  in  NREQ*SADDR  packed VAs; requester i is at [i*SADDR +: SADDR]
- `req_pcid`  in  NREQ*SPCID  packed PCIDs
- `resp_valid`  out  NREQ  one-hot response pulse
- `resp_pa`  out  SADDR  translated address
- `resp_fault`  out  1  walk fault
- `tlb_lookup`  out  1  lookup strobe
- `tlb_va`  out  SADDR  lookup/insert VA
- `tlb_pcid`  out  SPCID  lookup/insert PCID
- `tlb_hit`  in  1  lookup hit
- `tlb_miss`  in  1  lookup miss
- `tlb_ta`  in  SADDR  translated address on hit
- `tlb_insert`  out  1  insert strobe
- `tlb_pa`  out  SADDR  PA to insert
- `tlb_shutdown`  out  1  invalidate all entries
- `walk_req`  out  1  page-walk request (level)
- `walk_va`, `walk_pcid`  out  SADDR/SPCID  walk operands
- `walk_done`  in  1  walk complete pulse
- `walk_pa`  in  SADDR  walked PA
- `walk_fault`  in  1  walk fault, qualified by `walk_done`
- `flush_req`  in  1  flush request pulse
- `flush_done`  out  1  flush complete pulse
- `hit_cnt`, `miss_cnt`  out  32  saturating statistics

## Operation
- States: IDLE, LOOKUP, WAIT, WALK, FILL, RESP, FLUSH.
- Pending flush:
  - `flush_req` sets a `flush_pend` latch in any state.
  - IDLE with `flush_pend` goes to FLUSH. Flush takes priority over requests.
- IDLE grant:
  - Requester index is `g`. Grant goes to the first valid requester after `last_grant`, with wrap-around.
  - `req_ready[g]` is combinational and asserted only in IDLE with no pending flush.
  - On accept, latch va/pcid and `g`, set `last_grant<=g`, go to LOOKUP.
- LOOKUP: `tlb_lookup=1` for exactly one cycle with the latched `tlb_va`/`tlb_pcid`. Next state is WAIT and the timer clears.
- WAIT:
  - `tlb_hit` (and not `tlb_miss`): `resp_pa<=tlb_ta`, `hit_cnt++`, go to RESP.
  - `tlb_miss`, or hit and miss together (miss wins), or timer reaching `TIMEOUT-1`: `miss_cnt++`, go to WALK.
- WALK:
  - `walk_req` is held high with `walk_va`/`walk_pcid` stable until `walk_done`.
  - Fault: `resp_fault<=1`, `resp_pa<=0`, no insert, go to RESP.
  - No fault: go to FILL.
- FILL:
  - `tlb_insert=1` for one cycle, with `tlb_pa={walk_pa[SADDR-1:SPAGE], va[SPAGE-1:0]}`.
  - `resp_pa<=tlb_pa`, go to RESP.
- RESP: `resp_valid[g]=1` for one cycle. There is no backpressure; requesters must sink the response. Go to IDLE.
- FLUSH:
  - `tlb_shutdown=1` for `FLUSH_CYCLES` cycles, counted down.
  - After the last cycle, `flush_done` pulses once and `flush_pend` clears.
  - A `flush_req` during FLUSH is absorbed and does not trigger a second flush.
- Counters saturate at 2^32-1.

## Timing
- Reset (`rst` high at a `clk` edge):
  - State goes to IDLE.
  - All strobes, `req_ready`, `resp_valid`, `resp_fault`, `resp_pa`, `walk_req`, `tlb_shutdown`, `flush_done`, the counters, `flush_pend`, the timer and the flush counter are 0.
  - `last_grant` is NREQ-1, so requester 0 wins first.
  - Reset mid-walk or mid-flush aborts immediately. No response or `flush_done` is issued.
- Hit latency: accept at edge T, `tlb_lookup` in cycle T+1. With `tlb_hit` in cycle T+2, `resp_valid` is in cycle T+3.
- Miss latency: `walk_req` rises the cycle after `tlb_miss`. `tlb_insert` is the cycle after `walk_done`, and `resp_valid` the cycle after that.
- `walk_done` seen while not in WALK is ignored. `tlb_hit`/`tlb_miss` seen outside WAIT are ignored.
- At most one translation is in flight. Throughput is at most one request per 4 cycles (hit path: IDLE, LOOKUP, WAIT, RESP).

## Test plan
- Single hit: req0 VA 0x1234_5678, TLB returns `tlb_hit` with `tlb_ta`=0xABCD_E678 two cycles after accept. Required: `resp_valid`=01 one cycle later, `resp_pa`=0xABCD_E678, `hit_cnt`=1.
- Miss and fill: `tlb_miss`, then `walk_done` with `walk_pa`=0x7777_7000 and VA offset 0x678. Required: one `tlb_insert` with `tlb_pa`=0x7777_7678, then `resp_pa`=0x7777_7678, `miss_cnt`=1.
- Walk fault: `walk_done` with `walk_fault`=1. Required: no `tlb_insert`, `resp_fault`=1, `resp_pa`=0.
- Round-robin: both `req_valid` held high for 4 transactions. Required grant order 0,1,0,1.
- Flush during walk: `flush_req` pulsed while in WALK. Required: the walk completes and its response is issued, then `tlb_shutdown` is high for 2 cycles, then one `flush_done` pulse. `req_ready` stays 0 until FLUSH exits.
- Timeout and reset: TLB silent for 8 cycles after lookup. Required: `walk_req` rises. Then `rst` in WALK: all outputs 0 the next cycle and no response.

Source files
------------

// File: rtl/tlb_ctrl.sv
// TLB front-end sequencer: round-robin arbitration of translation requesters,
// lookup/walk/fill handshakes, flush sequencing and hit/miss statistics.
module tlb_ctrl #(
    parameter int SADDR        = 64,
    parameter int SPAGE        = 12,
    parameter int SPCID        = 12,
    parameter int NREQ         = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*SADDR-1:0]   req_va,
    input  logic [NREQ*SPCID-1:0]   req_pcid,
    output logic [NREQ-1:0]         resp_valid,
    output logic [SADDR-1:0]        resp_pa,
    output logic                    resp_fault,
    output logic                    tlb_lookup,
    output logic [SADDR-1:0]        tlb_va,
    output logic [SPCID-1:0]        tlb_pcid,
    input  logic                    tlb_hit,
    input  logic                    tlb_miss,
    input  logic [SADDR-1:0]        tlb_ta,
    output logic                    tlb_insert,
    output logic [SADDR-1:0]        tlb_pa,
    output logic                    tlb_shutdown,
    output logic                    walk_req,
    output logic [SADDR-1:0]        walk_va,
    output logic [SPCID-1:0]        walk_pcid,
    input  logic                    walk_done,
    input  logic [SADDR-1:0]        walk_pa,
    input  logic                    walk_fault,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WAIT, WALK, FILL, RESP, FLUSH
    } state_t;

    state_t          state, state_nx;
    logic            flush_pend;
    logic [GW-1:0]   last_grant, gnt_q, grant_idx;
    logic            grant_valid;
    logic [SADDR-1:0] va_q, wpa_q;
    logic [SPCID-1:0] pcid_q;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   flush_cnt;
    int unsigned     cand;
    logic [NREQ-1:0] rv_sh;
    logic            accept, wait_miss, wait_hit, flush_last;

    // First valid requester after last_grant, wrapping; shifts avoid wide index selects.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        rv_sh       = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand  = (32'(last_grant) + i) % NREQ;
            rv_sh = req_valid >> cand;
            if (!grant_valid && rv_sh[0]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(cand);
            end
        end
    end

    always_comb begin
        wait_hit   = tlb_hit && !tlb_miss;
        wait_miss  = tlb_miss || (!tlb_hit && timer == TW'(TIMEOUT - 1));
        flush_last = (flush_cnt == '0);
        accept     = (state == IDLE) && !flush_pend && grant_valid;
    end

    assign tlb_va    = va_q;
    assign tlb_pcid  = pcid_q;
    assign walk_va   = va_q;
    assign walk_pcid = pcid_q;
    assign tlb_pa    = {wpa_q[SADDR-1:SPAGE], va_q[SPAGE-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        req_ready    = '0;
        resp_valid   = '0;
        tlb_lookup   = 1'b0;
        tlb_insert   = 1'b0;
        tlb_shutdown = 1'b0;
        walk_req     = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    state_nx = FLUSH;
                end else if (grant_valid) begin
                    req_ready = NREQ'(1) << grant_idx;
                    state_nx  = LOOKUP;
                end
            end
            LOOKUP: begin
                tlb_lookup = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (wait_miss)     state_nx = WALK;
                else if (wait_hit) state_nx = RESP;
            end
            WALK: begin
                walk_req = 1'b1;
                if (walk_done) state_nx = walk_fault ? RESP : FILL;
            end
            FILL: begin
                tlb_insert = 1'b1;
                state_nx   = RESP;
            end
            RESP: begin
                resp_valid = NREQ'(1) << gnt_q;
                state_nx   = IDLE;
            end
            FLUSH: begin
                tlb_shutdown = 1'b1;
                if (flush_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            flush_cnt  <= '0;
            last_grant <= GW'(NREQ - 1);
            gnt_q      <= '0;
            va_q       <= '0;
            pcid_q     <= '0;
            wpa_q      <= '0;
            timer      <= '0;
            resp_pa    <= '0;
            resp_fault <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            flush_done <= 1'b0;
            // A request arriving during FLUSH is absorbed by the flush in progress.
            if (state == FLUSH && flush_last) flush_pend <= 1'b0;
            else if (flush_req)               flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (flush_pend) flush_cnt <= FW'(FLUSH_CYCLES - 1);
                    if (accept) begin
                        va_q       <= SADDR'(req_va >> (grant_idx * SADDR));
                        pcid_q     <= SPCID'(req_pcid >> (grant_idx * SPCID));
                        gnt_q      <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                LOOKUP: timer <= '0;
                WAIT: begin
                    timer <= timer + TW'(1);
                    if (wait_miss) begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                    end else if (wait_hit) begin
                        resp_pa    <= tlb_ta;
                        resp_fault <= 1'b0;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                    end
                end
                WALK: begin
                    if (walk_done) begin
                        if (walk_fault) begin
                            resp_fault <= 1'b1;
                            resp_pa    <= '0;
                        end else begin
                            wpa_q <= walk_pa;
                        end
                    end
                end
                FILL: begin
                    resp_pa    <= tlb_pa;
                    resp_fault <= 1'b0;
                end
                FLUSH: begin
                    if (flush_last) flush_done <= 1'b1;
                    else            flush_cnt  <= flush_cnt - FW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomized bench for tlb_ctrl: plays TLB and walker, predicts grant order,
// latencies, translated addresses, counters and flush sequencing.
module tb_tlb_ctrl;

    localparam int SADDR = 64;
    localparam int SPAGE = 12;
    localparam int SPCID = 12;
    localparam int NREQ  = 2;
    localparam int FC    = 2;
    localparam int TO    = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*SADDR-1:0] req_va;
    logic [NREQ*SPCID-1:0] req_pcid;
    logic [NREQ-1:0]       resp_valid;
    logic [SADDR-1:0]      resp_pa;
    logic                  resp_fault;
    logic                  tlb_lookup;
    logic [SADDR-1:0]      tlb_va;
    logic [SPCID-1:0]      tlb_pcid;
    logic                  tlb_hit;
    logic                  tlb_miss;
    logic [SADDR-1:0]      tlb_ta;
    logic                  tlb_insert;
    logic [SADDR-1:0]      tlb_pa;
    logic                  tlb_shutdown;
    logic                  walk_req;
    logic [SADDR-1:0]      walk_va;
    logic [SPCID-1:0]      walk_pcid;
    logic                  walk_done;
    logic [SADDR-1:0]      walk_pa;
    logic                  walk_fault;
    logic                  flush_req;
    logic                  flush_done;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    tlb_ctrl #(
        .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID),
        .NREQ(NREQ), .FLUSH_CYCLES(FC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_va(req_va), .req_pcid(req_pcid),
        .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_fault(resp_fault),
        .tlb_lookup(tlb_lookup), .tlb_va(tlb_va), .tlb_pcid(tlb_pcid),
        .tlb_hit(tlb_hit), .tlb_miss(tlb_miss), .tlb_ta(tlb_ta),
        .tlb_insert(tlb_insert), .tlb_pa(tlb_pa), .tlb_shutdown(tlb_shutdown),
        .walk_req(walk_req), .walk_va(walk_va), .walk_pcid(walk_pcid),
        .walk_done(walk_done), .walk_pa(walk_pa), .walk_fault(walk_fault),
        .flush_req(flush_req), .flush_done(flush_done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: who was served last and how many hits/misses so far.
    int last_g;
    int m_hit;
    int m_miss;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tlb_hit    = 1'b0;
        tlb_miss   = 1'b0;
        walk_done  = 1'b0;
        walk_fault = 1'b0;
        flush_req  = 1'b0;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int g);
        return NREQ'(32'd1 << g);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] rv);
        int unsigned v;
        int idx;
        v = 32'(rv);
        for (int i = 1; i <= NREQ; i++) begin
            idx = (last_g + i) % NREQ;
            if (((v >> idx) & 32'd1) != 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_g = NREQ - 1;
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_resp_pa", resp_pa, 0);
        check("rst_resp_fault", 64'(resp_fault), 0);
        check("rst_tlb_lookup", 64'(tlb_lookup), 0);
        check("rst_tlb_insert", 64'(tlb_insert), 0);
        check("rst_tlb_shutdown", 64'(tlb_shutdown), 0);
        check("rst_walk_req", 64'(walk_req), 0);
        check("rst_walk_va", walk_va, 0);
        check("rst_tlb_pa", tlb_pa, 0);
        check("rst_flush_done", 64'(flush_done), 0);
        check("rst_hit_cnt", 64'(hit_cnt), 0);
        check("rst_miss_cnt", 64'(miss_cnt), 0);
    endtask

    // IDLE with a pending flush, FC shutdown cycles, then the flush_done pulse.
    task automatic flush_tail();
        tick();
        req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        #1;
        check("pend_req_ready", 64'(req_ready), 0);
        check("pend_shutdown", 64'(tlb_shutdown), 0);
        for (int k = 0; k < FC; k++) begin
            tick();
            if ($urandom_range(0, 1) == 1) flush_req = 1'b1;
            #1;
            check("flush_shutdown", 64'(tlb_shutdown), 1);
            check("flush_req_ready", 64'(req_ready), 0);
            check("flush_done_early", 64'(flush_done), 0);
        end
        tick();
        req_valid = '0;
        #1;
        check("flush_done", 64'(flush_done), 1);
        check("flush_shutdown_off", 64'(tlb_shutdown), 0);
    endtask

    task automatic flush_idle();
        tick();
        req_valid = '0;
        flush_req = 1'b1;
        #1;
        check("idle_shutdown", 64'(tlb_shutdown), 0);
        flush_tail();
    endtask

    // kind: 0 hit, 1 miss, 2 hit+miss, 3 silent TLB (timeout).
    // fl: 0 none, 1 flush pulse in LOOKUP, 2 flush pulse in the first WALK cycle.
    task automatic txn(input logic [NREQ-1:0] rv, input int kind, input int d,
                       input int wlat, input bit fault, input int fl, input bit rst_walk,
                       input logic [SADDR-1:0] va_fix, input logic [SADDR-1:0] ta,
                       input logic [SADDR-1:0] wpa);
        logic [SADDR-1:0] va_a [NREQ];
        logic [SPCID-1:0] pc_a [NREQ];
        logic [SADDR-1:0] exp_pa;
        int g;
        int nw;
        bit fpend;
        fpend = 0;

        tick();
        req_va   = '0;
        req_pcid = '0;
        for (int i = 0; i < NREQ; i++) begin
            va_a[i]  = (va_fix != 0) ? va_fix : {$urandom, $urandom};
            pc_a[i]  = SPCID'($urandom);
            req_va   = req_va | ((NREQ*SADDR)'(va_a[i]) << (i * SADDR));
            req_pcid = req_pcid | ((NREQ*SPCID)'(pc_a[i]) << (i * SPCID));
        end
        req_valid = rv;
        #1;
        g = rr_pick(rv);
        check("idle_flush_done", 64'(flush_done), 0);
        check("req_ready", 64'(req_ready), 64'(onehot(g)));
        last_g = g;

        tick();
        req_valid = '0;
        if (fl == 1) begin
            flush_req = 1'b1;
            fpend = 1;
        end
        #1;
        check("tlb_lookup", 64'(tlb_lookup), 1);
        check("tlb_va", tlb_va, va_a[g]);
        check("tlb_pcid", 64'(tlb_pcid), 64'(pc_a[g]));
        check("lookup_req_ready", 64'(req_ready), 0);

        nw = (kind == 3) ? TO : d + 1;
        for (int k = 0; k < nw; k++) begin
            tick();
            if (kind != 3 && k == nw - 1) begin
                tlb_ta = ta;
                if (kind == 0 || kind == 2) tlb_hit  = 1'b1;
                if (kind == 1 || kind == 2) tlb_miss = 1'b1;
            end else begin
                walk_done = 1'($urandom);
            end
            #1;
            check("wait_quiet", 64'({tlb_lookup, walk_req, tlb_insert, resp_valid}), 0);
        end

        if (kind == 0) begin
            m_hit++;
            tick();
            #1;
            check("hit_resp_valid", 64'(resp_valid), 64'(onehot(g)));
            check("hit_resp_pa", resp_pa, ta);
            check("hit_resp_fault", 64'(resp_fault), 0);
            check("hit_cnt", 64'(hit_cnt), 64'(m_hit));
            check("hit_miss_cnt", 64'(miss_cnt), 64'(m_miss));
        end else begin
            m_miss++;
            for (int k = 0; k <= wlat; k++) begin
                tick();
                if (fl == 2 && k == 0) begin
                    flush_req = 1'b1;
                    fpend = 1;
                end
                if (rst_walk && k == 1) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    #1;
                    model_reset();
                    check_reset_outputs();
                    tick();
                    #1;
                    check("post_rst_resp", 64'(resp_valid), 0);
                    check("post_rst_flush_done", 64'(flush_done), 0);
                    return;
                end
                if (k == wlat) begin
                    walk_done  = 1'b1;
                    walk_pa    = wpa;
                    walk_fault = fault;
                end else begin
                    tlb_hit  = 1'($urandom);
                    tlb_miss = 1'($urandom);
                end
                #1;
                check("walk_req", 64'(walk_req), 1);
                check("walk_va", walk_va, va_a[g]);
                check("walk_pcid", 64'(walk_pcid), 64'(pc_a[g]));
                check("walk_quiet", 64'({resp_valid, tlb_insert}), 0);
                if (k == 0) begin
                    check("miss_cnt", 64'(miss_cnt), 64'(m_miss));
                    check("miss_hit_cnt", 64'(hit_cnt), 64'(m_hit));
                end
            end
            if (!fault) begin
                exp_pa = {wpa[SADDR-1:SPAGE], va_a[g][SPAGE-1:0]};
                tick();
                #1;
                check("fill_insert", 64'(tlb_insert), 1);
                check("fill_tlb_pa", tlb_pa, exp_pa);
                check("fill_walk_req", 64'(walk_req), 0);
                tick();
                #1;
                check("fill_resp_valid", 64'(resp_valid), 64'(onehot(g)));
                check("fill_resp_pa", resp_pa, exp_pa);
                check("fill_resp_fault", 64'(resp_fault), 0);
                check("fill_insert_off", 64'(tlb_insert), 0);
            end else begin
                tick();
                #1;
                check("fault_no_insert", 64'(tlb_insert), 0);
                check("fault_resp_valid", 64'(resp_valid), 64'(onehot(g)));
                check("fault_resp_fault", 64'(resp_fault), 1);
                check("fault_resp_pa", resp_pa, 0);
            end
        end

        if (fpend) flush_tail();
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        int kind, d, wlat, fl;
        bit fault;

        rst        = 1'b1;
        req_valid  = '0;
        req_va     = '0;
        req_pcid   = '0;
        tlb_hit    = 1'b0;
        tlb_miss   = 1'b0;
        tlb_ta     = '0;
        walk_done  = 1'b0;
        walk_pa    = '0;
        walk_fault = 1'b0;
        flush_req  = 1'b0;
        model_reset();
        tick();
        tick();
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Both requesters held: grants alternate starting from requester 0.
        for (int i = 0; i < 4; i++)
            txn(2'b11, 0, 1, 0, 0, 0, 0, '0, {$urandom, $urandom}, '0);

        txn(2'b01, 0, 0, 0, 0, 0, 0, 64'h1234_5678, 64'hABCD_E678, '0);
        txn(2'b01, 1, 0, 2, 0, 0, 0, 64'h1234_5678, '0, 64'h7777_7000);
        txn(2'b01, 1, 1, 1, 1, 0, 0, 64'h1234_5678, '0, 64'h5555_5000);
        txn(2'b10, 1, 0, 3, 0, 2, 0, '0, '0, 64'h3333_3000);
        txn(2'b11, 3, 0, 3, 0, 0, 1, '0, '0, '0);
        txn(2'b11, 0, 2, 0, 0, 0, 0, '0, 64'h0000_0000_9999_9123, '0);
        flush_idle();

        repeat (60) begin
            if ($urandom_range(0, 7) == 0) flush_idle();
            rv    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            kind  = $urandom_range(0, 3);
            d     = $urandom_range(0, TO - 2);
            wlat  = $urandom_range(0, 4);
            fault = ($urandom_range(0, 2) == 0);
            fl    = $urandom_range(0, 3);
            if (fl > 2) fl = 0;
            if (fl == 2 && kind == 0) fl = 1;
            txn(rv, kind, d, wlat, fault, fl, 0, '0, {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
